// File: rtl/memory_access_if.sv
// Execute-to-memory stage bus: instruction inputs from execute and completion
// outputs of the MEM stage. The master drives the execute side; the slave is the MEM stage.
interface memory_access_if #(
  parameter int DWIDTH       = 32,
  parameter int OPCODE_WIDTH = 6
);
  logic                    ms_i_ce;
  logic [OPCODE_WIDTH-1:0] ms_i_opcode;
  logic [DWIDTH-1:0]       ms_i_alu_value;
  logic [DWIDTH-1:0]       ms_i_data_rt;
  logic                    ms_o_ce;
  logic [OPCODE_WIDTH-1:0] ms_o_opcode;
  logic [DWIDTH-1:0]       ms_o_alu_value;
  logic [DWIDTH-1:0]       ms_o_load_data;
  logic                    ms_o_stall;
  logic                    ms_o_misaligned;

  modport master (
    output ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt,
    input  ms_o_ce, ms_o_opcode, ms_o_alu_value, ms_o_load_data, ms_o_stall, ms_o_misaligned
  );

  modport slave (
    input  ms_i_ce, ms_i_opcode, ms_i_alu_value, ms_i_data_rt,
    output ms_o_ce, ms_o_opcode, ms_o_alu_value, ms_o_load_data, ms_o_stall, ms_o_misaligned
  );
endinterface

// File: rtl/memory_access.sv
// MIPS MEM stage: byte/half/word loads and stores on a word RAM behind a wait-state FSM.
// Optional MS_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
module memory_access #(
  parameter int DWIDTH       = 32,
  parameter int DEPTH        = 256,
  parameter int MEM_LATENCY  = 2,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic ms_clk,
  input  logic ms_rst,
  memory_access_if.slave ms
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic [DWIDTH-1:0]       addr_q, addr_d;
  logic [DWIDTH-1:0]       data_q, data_d;
  logic                    o_ce_q, o_ce_d;
  logic [OPCODE_WIDTH-1:0] o_op_q, o_op_d;
  logic [DWIDTH-1:0]       o_alu_q, o_alu_d;
  logic [DWIDTH-1:0]       o_ld_q, o_ld_d;
  logic                    stall_q, stall_d;
  logic                    mis_q, mis_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] widx;
  logic [1:0]    lane_mask;
  logic [1:0]    off;
  logic [31:0]   rword, shifted, ext, wdata;
  logic [3:0]    be;
  logic          mis, we, op_is_load, op_is_store, in_is_mem;

  function automatic logic is_load(input logic [OPCODE_WIDTH-1:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  // lane_mask keeps only the address bits that select a lane for the access size
  always_comb begin
    op_is_load  = is_load(op_q);
    op_is_store = is_store(op_q);
    in_is_mem   = is_load(ms.ms_i_opcode) || is_store(ms.ms_i_opcode);
    widx        = addr_q[AW+1:2];
    if (op_q == OP_LW || op_q == OP_SW)                        lane_mask = 2'b00;
    else if (op_q == OP_LH || op_q == OP_LHU || op_q == OP_SH) lane_mask = 2'b10;
    else                                                        lane_mask = 2'b11;
    off     = addr_q[1:0] & lane_mask;
`ifdef MS_MISALIGN_TRAP_EN
    mis     = |(addr_q[1:0] & ~lane_mask);
`else
    mis     = 1'b0;
`endif
    rword   = mem[widx];
    shifted = rword >> {off, 3'b000};
    ext     = '0;
    case (op_q)
      OP_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  ext = {24'h0, shifted[7:0]};
      OP_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  ext = {16'h0, shifted[15:0]};
      OP_LW:   ext = shifted;
      default: ext = '0;
    endcase
    wdata = data_q;
    be    = 4'b1111;
    if (op_q == OP_SB) begin
      wdata = {4{data_q[7:0]}};
      be    = 4'b0001 << off;
    end else if (op_q == OP_SH) begin
      wdata = {2{data_q[15:0]}};
      be    = off[1] ? 4'b1100 : 4'b0011;
    end
    we = (state_q == DONE) && op_is_store && !mis;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    o_ce_d  = 1'b0;
    o_op_d  = o_op_q;
    o_alu_d = o_alu_q;
    o_ld_d  = o_ld_q;
    stall_d = stall_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (ms.ms_i_ce) begin
          if (in_is_mem) begin
            op_d    = ms.ms_i_opcode;
            addr_d  = ms.ms_i_alu_value;
            data_d  = ms.ms_i_data_rt;
            stall_d = 1'b1;
            cnt_d   = CW'(MEM_LATENCY - 1);
            state_d = (MEM_LATENCY > 1) ? WAIT : DONE;
          end else begin
            o_ce_d  = 1'b1;
            o_op_d  = ms.ms_i_opcode;
            o_alu_d = ms.ms_i_alu_value;
            o_ld_d  = '0;
            mis_d   = 1'b0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        o_ce_d  = 1'b1;
        o_op_d  = op_q;
        o_alu_d = addr_q;
        o_ld_d  = (op_is_load && !mis) ? ext : '0;
        mis_d   = mis;
        stall_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ms_clk or posedge ms_rst) begin
    if (ms_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      o_ce_q  <= 1'b0;
      o_op_q  <= '0;
      o_alu_q <= '0;
      o_ld_q  <= '0;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      o_ce_q  <= o_ce_d;
      o_op_q  <= o_op_d;
      o_alu_q <= o_alu_d;
      o_ld_q  <= o_ld_d;
      stall_q <= stall_d;
      mis_q   <= mis_d;
    end
  end

  // RAM is not reset; the write is gated by DONE, so a reset during WAIT drops the store
  always_ff @(posedge ms_clk) begin
    if (we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign ms.ms_o_ce          = o_ce_q;
  assign ms.ms_o_opcode      = o_op_q;
  assign ms.ms_o_alu_value   = o_alu_q;
  assign ms.ms_o_load_data   = o_ld_q;
  assign ms.ms_o_stall       = stall_q;
  assign ms.ms_o_misaligned  = mis_q;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed MEM-stage cases plus random traffic against
// a byte-arithmetic reference memory.
module tb_memory_access;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] obs_ld;

  memory_access_if #(.DWIDTH(32), .OPCODE_WIDTH(6)) bus ();

  memory_access #(.DWIDTH(32), .DEPTH(DEPTH), .MEM_LATENCY(LAT), .OPCODE_WIDTH(6)) dut (
    .ms_clk (clk),
    .ms_rst (rst),
    .ms     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic mem_op(input logic [5:0] op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  // Reference: word index and lane picked arithmetically from the byte address
  task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       output logic [31:0] ld, output logic mis);
    int unsigned w, b, size;
    logic [31:0] val, msk;
    w    = (addr / 4) % DEPTH;
    b    = addr % 4;
    size = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
    mis  = 1'b0;
    ld   = 32'h0;
    if (!mem_op(op)) return;
    if (b % size != 0) begin
`ifdef MS_MISALIGN_TRAP_EN
      mis = 1'b1;
`endif
      b = b - (b % size);
    end
    if (mis) return;
    val = ref_mem[w] >> (8 * b);
    case (op)
      LB:  ld = (val % 256 >= 128) ? (val % 256) + 32'hFFFFFF00 : val % 256;
      LBU: ld = val % 256;
      LH:  ld = (val % 65536 >= 32768) ? (val % 65536) + 32'hFFFF0000 : val % 65536;
      LHU: ld = val % 65536;
      LW:  ld = ref_mem[w];
      default: begin
        msk = (size == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * size)) - 1) << (8 * b);
        ref_mem[w] = (ref_mem[w] & ~msk) | ((rt << (8 * b)) & msk);
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the completion pulse
  task automatic run(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                     output logic [31:0] ld_o);
    logic [31:0] exp_ld;
    logic        exp_mis;
    int          stalls, guard;
    model(op, addr, rt, exp_ld, exp_mis);
    bus.ms_i_ce        = 1'b1;
    bus.ms_i_opcode    = op;
    bus.ms_i_alu_value = addr;
    bus.ms_i_data_rt   = rt;
    @(negedge clk);
    bus.ms_i_ce = 1'b0;
    stalls = 0;
    guard  = 0;
    while (bus.ms_o_ce !== 1'b1 && guard < 20) begin
      if (bus.ms_o_stall === 1'b1) begin
        stalls++;
        bus.ms_i_ce        = 1'b1;
        bus.ms_i_opcode    = 6'(op ^ 6'h01);
        bus.ms_i_alu_value = $urandom;
      end
      @(negedge clk);
      guard++;
    end
    bus.ms_i_ce = 1'b0;
    check("done_in_time", 32'(guard < 20), 32'd1);
    check("stall_cycles", stalls, mem_op(op) ? LAT : 0);
    check("stall_low_at_done", 32'(bus.ms_o_stall), 32'd0);
    check("opcode", 32'(bus.ms_o_opcode), 32'(op));
    check("alu_value", bus.ms_o_alu_value, addr);
    check("load_data", bus.ms_o_load_data, exp_ld);
    check("misaligned", 32'(bus.ms_o_misaligned), 32'(exp_mis));
    ld_o = bus.ms_o_load_data;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ce"},    32'(bus.ms_o_ce), 32'd0);
    check({tag, "_stall"}, 32'(bus.ms_o_stall), 32'd0);
    check({tag, "_alu"},   bus.ms_o_alu_value, 32'd0);
    check({tag, "_ld"},    bus.ms_o_load_data, 32'd0);
    check({tag, "_op"},    32'(bus.ms_o_opcode), 32'd0);
    check({tag, "_mis"},   32'(bus.ms_o_misaligned), 32'd0);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    bus.ms_i_ce = 1'b0;
    bus.ms_i_opcode = '0;
    bus.ms_i_alu_value = '0;
    bus.ms_i_data_rt = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Non-memory pass-through; the pulse must be a single cycle and the value held
    run(6'h00, 32'd9, 32'h0, obs_ld);
    @(negedge clk);
    check("ce_pulse_ends", 32'(bus.ms_o_ce), 32'd0);
    check("alu_holds", bus.ms_o_alu_value, 32'd9);

    for (int w = 0; w < DEPTH; w++) run(SW, 32'(w * 4), $urandom | 32'h100, obs_ld);

    run(SW, 32'h10, 32'hDEADBEEF, obs_ld);
    run(LW, 32'h10, 32'h0, obs_ld);
    check("lw_after_sw", obs_ld, 32'hDEADBEEF);
    run(SB, 32'h11, 32'h80, obs_ld);
    run(LB, 32'h11, 32'h0, obs_ld);
    check("lb_sign", obs_ld, 32'hFFFFFF80);
    run(LBU, 32'h11, 32'h0, obs_ld);
    check("lbu_zero", obs_ld, 32'h00000080);
    run(LW, 32'h10, 32'h0, obs_ld);
    check("lw_after_sb", obs_ld, 32'hDEAD80EF);
    run(SW, 32'(DEPTH * 4 + 4), 32'd5, obs_ld);
    run(LW, 32'h4, 32'h0, obs_ld);
    check("wrap", obs_ld, 32'd5);
    run(LW, 32'h12, 32'h0, obs_ld);
`ifdef MS_MISALIGN_TRAP_EN
    check("misaligned_lw", obs_ld, 32'h0);
`else
    check("misaligned_lw", obs_ld, 32'hDEAD80EF);
`endif

    // Reset one cycle after accepting a store: no completion, store discarded
    bus.ms_i_ce = 1'b1;
    bus.ms_i_opcode = SW;
    bus.ms_i_alu_value = 32'h20;
    bus.ms_i_data_rt = 32'd7;
    @(negedge clk);
    bus.ms_i_ce = 1'b0;
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid_wait");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_ce_after_rst", 32'(bus.ms_o_ce), 32'd0);
    end
    run(LW, 32'h20, 32'h0, obs_ld);
    check("store_dropped", 32'(obs_ld != 32'd7), 32'd1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 8))
        0: op = LB;  1: op = LH;  2: op = LW;  3: op = LBU; 4: op = LHU;
        5: op = SB;  6: op = SH;  7: op = SW;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (mem_op(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      a = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, DEPTH * 4 - 1));
      run(op, a, $urandom, obs_ld);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        check("idle_no_ce", 32'(bus.ms_o_ce), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
